mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
- Multicycle MIPS control unit; it is the initiator side of the ALU interface.
- Sequences each instruction through a Moore FSM and drives `alu_control`, operand selects and datapath write strobes. Consumes the ALU's `zero` flag.
- The ALU registers `ALUresult` and `zero` on posedge `clk`. Every ALU operation issued in state S is therefore visible one state later, and the FSM is scheduled around that latency.
- Sits between the instruction register (opcode/funct) and the datapath (PC, IR, register file, memory, ALU).

Parameters:
- STATE_W, 4, width of state register and `state` debug port.
- EN_ADDI, 1, 1 = decode addi (opcode 0x08); 0 = addi treated as unknown opcode.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset. One clock; reset is synchronous, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (registered; updated only by subtract).
- alu_control  out  4  ALU op: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2.
- pc_source  out  2  00 = ALUresult, 01 = ALUOut reg, 10 = jump target {PC[31:28], IR[25:0], 2'b00}.
- pc_en  out  1  PC write strobe.
- iord  out  1  memory address: 0 = PC, 1 = ALUresult.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load strobe.
- reg_write  out  1  register-file write strobe.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUresult, 1 = memory data reg.
- alu_out_write  out  1  ALUOut capture strobe.
- state  out  STATE_W  current state (debug).

Behaviour:
- **Outputs.** Moore outputs are decoded from the state register. The only exception is `pc_en` in BRRES, which equals `zero`. Any strobe or select not listed for a state is 0 in that state.
- **Reset.**
  - `rst` high at posedge puts the state in FETCH.
  - While `rst` is high, `pc_en`, `ir_write`, `reg_write`, `mem_write` and `alu_out_write` are forced to 0.
  - Other outputs take their FETCH values: `alu_control`=0010, `alu_src_a`=0, `alu_src_b`=01, `iord`=0, `mem_read`=1, `reg_dst`=0, `mem_to_reg`=0, `pc_source`=00, `state`=0.
  - A reset asserted in any state aborts the instruction with no further writes.
- **States** (encoding in brackets):
  - FETCH(0): `mem_read`, `ir_write`, `iord`=0; ALU add PC+4 (src_a=0, src_b=01). Next: DECODE.
  - DECODE(1): `pc_en`, `pc_source`=00, writing PC+4 now present on ALUresult. Next by opcode:
    - 0x00 → EXEC
    - 0x23 or 0x2B → MEMADR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - 0x08 with EN_ADDI=1 → ADDIEX
    - any other opcode → FETCH (NOP; 2 cycles total).
  - MEMADR(2): add A+sext(imm). Next: MEMRD for 0x23, MEMWR for 0x2B.
  - MEMRD(3): `mem_read`, `iord`=1. Next: MEMWB.
  - MEMWB(4): `reg_write`, `reg_dst`=0, `mem_to_reg`=1. Next: FETCH.
  - MEMWR(5): `mem_write`, `iord`=1. Next: FETCH.
  - EXEC(6): src_a=1, src_b=00. `alu_control` by funct: 0x20 → 0010, 0x22 → 0110, 0x24 → 0000, 0x25 → 0001, 0x2A → 0111.
    - Supported funct → ALUWB.
    - Unknown funct → `alu_control`=0010, next FETCH, no register write.
  - ALUWB(7): `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Next: FETCH.
  - BRANCH(8): add PC+(sext(imm)<<2) (src_a=0, src_b=11). Next: BRCMP.
  - BRCMP(9): sub A−B (src_a=1, src_b=00); `alu_out_write`=1, capturing the target now on ALUresult. Next: BRRES.
  - BRRES(10): `pc_en`=`zero`, `pc_source`=01. Next: FETCH.
  - JUMP(11): `pc_en`, `pc_source`=10. Next: FETCH.
  - ADDIEX(12): add A+sext(imm). Next: ADDIWB.
  - ADDIWB(13): `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Next: FETCH.
  - Codes 14–15: illegal. Next: FETCH, all strobes 0.
- **Latencies in cycles:** lw 5, sw 4, R-type 4, beq 5, j 3, addi 4, unknown opcode 2, unknown funct 3.
- **Zero flag.** `zero` is sampled only in BRRES. It was refreshed by the BRCMP subtract, so stale values from earlier instructions cannot affect branches.

Decomposition:
- Package `mips_pkg` holds:
  - state localparams;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`;
  - funct constants;
  - ALU op codes `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`.
- The ALU op codes are shared with the ALU block.
- One sub-module, `mips_alu_decode`: purely combinational; maps (state, funct) to `alu_control` plus an unknown-funct flag.

Test Plan:
- **Reset mid-instruction.** Reset, then opcode=0x23 (lw) → states 0,1,2,3,4,0. `mem_read` in 0 and 3; `pc_en` only in 1; `reg_write`+`mem_to_reg` only in 4; `alu_control`=0010 in 0 and 2. Then assert `rst` in state 3 → next state 0, with all write strobes 0 while `rst` is high.
- **R-type dispatch.** opcode=0x00:
  - funct=0x22 → `alu_control`=0110 in EXEC, `reg_write`+`reg_dst`=1 in ALUWB, 4 cycles.
  - Repeat for 0x24→0000, 0x25→0001, 0x2A→0111.
- **beq.** opcode=0x04:
  - `zero`=1 in BRRES → `pc_en`=1, `pc_source`=01, `alu_out_write`=1 in BRCMP.
  - `zero`=0 → `pc_en`=0; 5 cycles either way.
- **sw, j, addi.**
  - opcode=0x2B → `mem_write`=1, `iord`=1 in MEMWR only; 4 cycles.
  - opcode=0x02 → `pc_en`=1, `pc_source`=10 in JUMP; 3 cycles.
  - opcode=0x08 → 4 cycles; `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 in ADDIWB.
- **Unknown codes.**
  - opcode=0x3F → DECODE→FETCH, no `reg_write`/`mem_write`.
  - R-type funct=0x00 → EXEC→FETCH, `alu_control`=0010, `reg_write` never asserted.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode, funct and ALU op encodings for the multicycle MIPS control
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_BRCMP  = 4'd9,
    S_BRRES  = 4'd10,
    S_JUMP   = 4'd11,
    S_ADDIEX = 4'd12,
    S_ADDIWB = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - combinational map from (state, funct) to ALU op and unknown-funct flag
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       funct_bad
);

  // States that do not use the ALU still present a harmless add.
  always_comb begin
    alu_control = ALU_ADD;
    funct_bad   = 1'b0;
    case (state)
      S_BRCMP: alu_control = ALU_SUB;
      S_EXEC: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: funct_bad   = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS Moore control FSM driving ALU op, selects and datapath strobes
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [3:0]         alu_control,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_out_write,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d, state_eff;
  logic   funct_bad;
  logic   pc_en_raw, mem_write_raw, ir_write_raw, reg_write_raw, alu_out_write_raw;

  // During reset every output shows FETCH values so the datapath sees a clean fetch setup.
  assign state_eff = rst ? S_FETCH : state_q;

  mips_alu_decode u_alu_decode (
    .state       (state_eff),
    .funct       (funct),
    .alu_control (alu_control),
    .funct_bad   (funct_bad)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = EN_ADDI ? S_ADDIEX : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = funct_bad ? S_FETCH : S_ALUWB;
      S_BRANCH: state_d = S_BRCMP;
      S_BRCMP:  state_d = S_BRRES;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    pc_source         = 2'b00;
    pc_en_raw         = 1'b0;
    iord              = 1'b0;
    mem_read          = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    alu_out_write_raw = 1'b0;
    case (state_eff)
      S_FETCH: begin
        mem_read     = 1'b1;
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b01;
      end
      S_DECODE: pc_en_raw = 1'b1;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
      end
      S_EXEC:   alu_src_a = 1'b1;
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_BRANCH: alu_src_b = 2'b11;
      S_BRCMP: begin
        alu_src_a         = 1'b1;
        alu_out_write_raw = 1'b1;
      end
      // zero here reflects the BRCMP subtract, registered by the ALU.
      S_BRRES: begin
        pc_en_raw = zero;
        pc_source = 2'b01;
      end
      S_JUMP: begin
        pc_en_raw = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      default: ;
    endcase
  end

  assign pc_en         = pc_en_raw & ~rst;
  assign mem_write     = mem_write_raw & ~rst;
  assign ir_write      = ir_write_raw & ~rst;
  assign reg_write     = reg_write_raw & ~rst;
  assign alu_out_write = alu_out_write_raw & ~rst;
  assign state         = STATE_W'(state_eff);

endmodule
